load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width.
REQ-002 Parameter DATA_W, default 64, data width; only 64 is supported.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles spent in WAIT before an error response.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req_valid  in  1  core request present.
REQ-007 o_req_ready  out  1  unit can accept a request.
REQ-008 i_req_store  in  1  1 = store, 0 = load.
REQ-009 i_req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 i_req_addr  in  ADDR_W  byte address.
REQ-011 i_req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 o_resp_valid  out  1  one-cycle completion pulse.
REQ-013 o_resp_data  out  DATA_W  load result, extended per funct3; 0 for stores.
REQ-014 o_resp_err  out  1  error flag, qualified by o_resp_valid.
REQ-015 o_MemRead / o_MemWrite  out  1 each  data-memory read/write strobes.
REQ-016 o_r_addr / o_w_addr  out  ADDR_W each  data-memory read/write addresses.
REQ-017 o_mem_data  out  DATA_W  8-byte write data, little-endian at o_w_addr.
REQ-018 i_mem_valid / i_mem_data  in  1 / DATA_W  data-memory read response.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WAIT, WR and RESP; o_req_ready is 1 only in IDLE.
REQ-020 The unit SHALL accept a request when i_req_valid and o_req_ready are both high, latching store, funct3, addr and wdata.
REQ-021 Transitions from IDLE on accept SHALL be: SD goes to WR; every other request (all loads, SB/SH/SW) goes to RD.
REQ-022 RD SHALL last one cycle with o_MemRead=1 and o_r_addr=latched address, then go to WAIT.
REQ-023 In WAIT, i_mem_valid=1 SHALL capture i_mem_data; the unit then goes to RESP for loads and to WR for stores.
REQ-024 WR SHALL last one cycle with o_MemWrite=1 and o_w_addr=address, then go to RESP.
REQ-025 For SD, o_mem_data SHALL equal wdata; for SB/SH/SW it SHALL equal the captured data with low 1/2/4 bytes replaced by wdata's low bytes (read-modify-write).
REQ-026 Load results SHALL use the low 1/2/4/8 bytes of the captured data, sign-extended for B/H/W and zero-extended for BU/HU/WU.
REQ-027 RESP SHALL last one cycle with o_resp_valid=1, then return to IDLE; there is no response backpressure.
REQ-028 Latency from accept cycle 0 with a 2-cycle memory SHALL be: load response in cycle 4, SD in cycle 2, SB/SH/SW in cycle 5.
REQ-029 A WAIT cycle counter SHALL trigger a timeout after TIMEOUT cycles without i_mem_valid: go to RESP with o_resp_err=1 and o_resp_data=0, with no write issued.
REQ-030 i_mem_valid SHALL be ignored outside WAIT, which covers stale responses after a timeout or reset.
REQ-031 funct3 111, or a store with funct3 of 100/101/110, SHALL go directly IDLE to RESP with o_resp_err=1 and no memory access.
REQ-032 o_MemRead and o_MemWrite SHALL be registered and never high together.

Reset
REQ-033 Asserting i_rst_n low at any time, including mid-RMW, SHALL asynchronously force IDLE, clear all outputs and counters to 0, and abort any pending write.

Configuration
REQ-034 With macro LSU_MISALIGN_CHECK_EN defined, an access whose address is not a multiple of its size SHALL respond IDLE to RESP with o_resp_err=1 and no memory access.
REQ-035 With LSU_MISALIGN_CHECK_EN undefined, misaligned accesses SHALL proceed normally, since memory is byte-addressable.

Structure
REQ-036 A shared package SHALL hold the state enum, funct3 constants and the default TIMEOUT.
REQ-037 The combinational byte merge and extension SHALL be implemented in sub-module lsu_align.

Verification
REQ-038 LD at 0x10 with memory holding 0x8877665544332211: o_MemRead in cycle 1; o_resp_valid in cycle 4 with data 0x8877665544332211 and err 0.
REQ-039 SB of 0xAB at 0x20 over 0x1111111111111111: RD then WR; o_mem_data=0x11111111111111AB; a subsequent LBU returns 0xAB and LB returns 0xFFFFFFFFFFFFFFAB.
REQ-040 SD of 0xDEADBEEF00000000 at 0x8: o_MemWrite in cycle 1, response in cycle 2, o_MemRead never asserted.
REQ-041 Load with i_mem_valid held at 0: o_resp_err=1 after 16 WAIT cycles; a late i_mem_valid pulse produces no extra response.
REQ-042 i_rst_n pulsed low during WAIT of an SH: all outputs 0 immediately, no o_MemWrite, o_req_ready=1 after release.
REQ-043 LW at 0x3: with LSU_MISALIGN_CHECK_EN defined, err in cycle 1 with no access; without it, a normal response in cycle 4.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings,
// default WAIT timeout and small decode helpers.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    // Unsigned sizes have no store form; 111 is never a valid size.
    function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
        return (funct3 == F3_BAD) || (store && funct3[2]);
    endfunction

    function automatic logic [2:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load extension (sign/zero, 1/2/4/8 bytes) and
// read-modify-write byte merge of store data into the captured memory word.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] store_data_o
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(DATA_W-8){rdata_i[7]}},   rdata_i[7:0]};
            F3_H:    load_data_o = {{(DATA_W-16){rdata_i[15]}}, rdata_i[15:0]};
            F3_W:    load_data_o = {{(DATA_W-32){rdata_i[31]}}, rdata_i[31:0]};
            F3_BU:   load_data_o = {{(DATA_W-8){1'b0}},         rdata_i[7:0]};
            F3_HU:   load_data_o = {{(DATA_W-16){1'b0}},        rdata_i[15:0]};
            F3_WU:   load_data_o = {{(DATA_W-32){1'b0}},        rdata_i[31:0]};
            default: load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        store_data_o = wdata_i;
        case (funct3_i[1:0])
            2'd0:    store_data_o = {rdata_i[DATA_W-1:8],  wdata_i[7:0]};
            2'd1:    store_data_o = {rdata_i[DATA_W-1:16], wdata_i[15:0]};
            2'd2:    store_data_o = {rdata_i[DATA_W-1:32], wdata_i[31:0]};
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding FSM with read-modify-write for sub-word stores
// and a WAIT timeout. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data,
    output logic              o_resp_err,
    output logic              o_MemRead,
    output logic              o_MemWrite,
    output logic [ADDR_W-1:0] o_r_addr,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;
    logic              misaligned;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = |(i_req_addr[2:0] & size_mask(i_req_funct3));
`else
    assign misaligned = 1'b0;
`endif

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i     (funct3_q),
        .rdata_i      (i_mem_data),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        r_addr_d     = '0;
        w_addr_d     = '0;
        mem_data_d   = '0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    store_d  = i_req_store;
                    funct3_d = i_req_funct3;
                    addr_d   = i_req_addr;
                    wdata_d  = i_req_wdata;
                    if (funct3_illegal(i_req_store, i_req_funct3) || misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (i_req_store && (i_req_funct3 == F3_D)) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        w_addr_d    = i_req_addr;
                        mem_data_d  = i_req_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        r_addr_d   = i_req_addr;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (i_mem_valid) begin
                    if (store_q) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        w_addr_d    = addr_q;
                        mem_data_d  = merge_data;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = load_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Timed out: the pending write of an RMW is dropped.
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset clears only these control/output registers, no memory.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            r_addr_q     <= '0;
            w_addr_q     <= '0;
            mem_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            r_addr_q     <= r_addr_d;
            w_addr_q     <= w_addr_d;
            mem_data_q   <= mem_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_req_ready  = (state_q == ST_IDLE) && i_rst_n;
    assign o_MemRead    = mem_read_q;
    assign o_MemWrite   = mem_write_q;
    assign o_r_addr     = r_addr_q;
    assign o_w_addr     = w_addr_q;
    assign o_mem_data   = mem_data_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_data  = resp_data_q;
    assign o_resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array memory model predicts a
// per-cycle expectation table that one compare process checks every cycle.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] r_addr;
    logic [63:0] w_addr;
    logic [63:0] mem_wdata;
    logic        mem_valid;
    logic [63:0] mem_rdata;

    load_store_unit #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_store  (req_store),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err),
        .o_MemRead    (mem_read),
        .o_MemWrite   (mem_write),
        .o_r_addr     (r_addr),
        .o_w_addr     (w_addr),
        .o_mem_data   (mem_wdata),
        .i_mem_valid  (mem_valid),
        .i_mem_data   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ready;
        logic        rd;
        logic        wr;
        logic [63:0] raddr;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic        rv;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t       exp_tab [int];
    logic [7:0] mem [longint];
    bit         check_en = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    int          n_resp = 0, n_reads = 0, n_writes = 0;
    int          last_resp_cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    logic [63:0] last_resp_data = '0;
    logic        last_resp_err = 1'b0;
    logic [63:0] last_wr_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cyc, act, expv);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: '0};
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t busy_exp();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic logic [63:0] mem_rd8(input longint a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++)
            v[8*i +: 8] = mem.exists(a + i) ? mem[a + i] : 8'h00;
        return v;
    endfunction

    function automatic void mem_wr8(input longint a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem[a + i] = v[8*i +: 8];
    endfunction

    function automatic logic [63:0] load_ext(input logic [63:0] raw, input int n, input bit sgn);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v = raw & mask;
        if (sgn && n < 8 && raw[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input int n);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < n; i++) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Per-cycle compare against the expectation table (idle outputs if unplanned).
    always @(negedge clk) begin
        exp_t e;
        if (check_en && rst_n) begin
            if (exp_tab.exists(cyc)) e = exp_tab[cyc];
            else e = idle_exp();
            check("req_ready",  64'(req_ready),  64'(e.ready));
            check("MemRead",    64'(mem_read),   64'(e.rd));
            check("MemWrite",   64'(mem_write),  64'(e.wr));
            check("r_addr",     r_addr,          e.raddr);
            check("w_addr",     w_addr,          e.waddr);
            check("mem_data",   mem_wdata,       e.wdata);
            check("resp_valid", 64'(resp_valid), 64'(e.rv));
            check("resp_data",  resp_data,       e.rdata);
            check("resp_err",   64'(resp_err),   64'(e.err));
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            last_resp_cyc  = cyc;
            last_resp_data = resp_data;
            last_resp_err  = resp_err;
        end
        if (mem_read) begin
            n_reads++;
            last_rd_cyc = cyc;
        end
        if (mem_write) begin
            n_writes++;
            last_wr_cyc  = cyc;
            last_wr_data = mem_wdata;
        end
    end

    task automatic set_exp(input int k, input exp_t e);
        exp_tab[k] = e;
    endtask

    // lat: cycles from the read strobe to i_mem_valid; 0 = memory never answers.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input int lat, output int c0);
        longint      n;
        bit          sgn, bad;
        int          c_end, v;
        logic [63:0] raw, mrg;
        exp_t        e;
        n   = longint'(1) << f3[1:0];
        sgn = !f3[2];
        bad = (f3 == 3'b111) || (st && f3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((addr % 64'(n)) != 0) bad = 1'b1;
`endif
        raw = mem_rd8(longint'(addr));
        v   = -1;
        @(posedge clk); #1;
        c0         = cyc;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;

        if (bad) c_end = c0 + 1;
        else if (st && f3 == 3'b011) c_end = c0 + 2;
        else if (lat >= 1 && lat - 1 < TO) c_end = c0 + 1 + lat + (st ? 2 : 1);
        else c_end = c0 + 2 + TO;
        for (int k = c0 + 1; k <= c_end; k++) set_exp(k, busy_exp());

        if (bad) begin
            e = busy_exp(); e.rv = 1'b1; e.err = 1'b1; set_exp(c0 + 1, e);
        end else if (st && f3 == 3'b011) begin
            e = busy_exp(); e.wr = 1'b1; e.waddr = addr; e.wdata = wd; set_exp(c0 + 1, e);
            e = busy_exp(); e.rv = 1'b1; set_exp(c0 + 2, e);
            mem_wr8(longint'(addr), wd);
        end else begin
            e = busy_exp(); e.rd = 1'b1; e.raddr = addr; set_exp(c0 + 1, e);
            if (lat >= 1 && lat - 1 < TO) begin
                v = c0 + 1 + lat;
                if (!st) begin
                    e = busy_exp(); e.rv = 1'b1; e.rdata = load_ext(raw, int'(n), sgn); set_exp(v + 1, e);
                end else begin
                    mrg = merge(raw, wd, int'(n));
                    e = busy_exp(); e.wr = 1'b1; e.waddr = addr; e.wdata = mrg; set_exp(v + 1, e);
                    e = busy_exp(); e.rv = 1'b1; set_exp(v + 2, e);
                    mem_wr8(longint'(addr), mrg);
                end
            end else begin
                e = busy_exp(); e.rv = 1'b1; e.err = 1'b1; set_exp(c_end, e);
            end
        end

        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = c0 + 1; k <= c_end; k++) begin
            mem_valid = (lat >= 1) && (k == c0 + 1 + lat);
            mem_rdata = mem_valid ? raw : 64'h0;
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        mem_rdata = 64'h0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; mem_valid = 1'b0; mem_rdata = '0;
        mem_wr8(64'h00, 64'h0706050403020100);
        mem_wr8(64'h10, 64'h8877665544332211);
        mem_wr8(64'h20, 64'h1111111111111111);
        mem_wr8(64'h30, 64'h000000008000F00D);

        #22;
        check("reset_ready",      64'(req_ready),  64'h0);
        check("reset_resp_valid", 64'(resp_valid), 64'h0);
        check("reset_MemRead",    64'(mem_read),   64'h0);
        check("reset_MemWrite",   64'(mem_write),  64'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_reset_ready", 64'(req_ready), 64'h1);
        check_en = 1'b1;
        idle(2);

        // LD 0x10: read in cycle 1, response in cycle 4.
        run_txn(1'b0, 3'b011, 64'h10, 64'h0, 2, c0);
        check("ld_read_cycle", 64'(last_rd_cyc - c0),   64'd1);
        check("ld_resp_cycle", 64'(last_resp_cyc - c0), 64'd4);
        check("ld_data",       last_resp_data,          64'h8877665544332211);
        check("ld_err",        64'(last_resp_err),      64'h0);

        // SB 0xAB at 0x20: read-modify-write, response in cycle 5.
        run_txn(1'b1, 3'b000, 64'h20, 64'hFFFF_FFFF_FFFF_FFAB, 2, c0);
        check("sb_wdata",      last_wr_data,            64'h11111111111111AB);
        check("sb_wr_cycle",   64'(last_wr_cyc - c0),   64'd4);
        check("sb_resp_cycle", 64'(last_resp_cyc - c0), 64'd5);
        run_txn(1'b0, 3'b100, 64'h20, 64'h0, 2, c0);
        check("lbu_data", last_resp_data, 64'h00000000000000AB);
        run_txn(1'b0, 3'b000, 64'h20, 64'h0, 2, c0);
        check("lb_data",  last_resp_data, 64'hFFFFFFFFFFFFFFAB);

        // SD: write in cycle 1, response in cycle 2, no read.
        base = n_reads;
        run_txn(1'b1, 3'b011, 64'h8, 64'hDEADBEEF00000000, 2, c0);
        check("sd_wr_cycle",   64'(last_wr_cyc - c0),   64'd1);
        check("sd_resp_cycle", 64'(last_resp_cyc - c0), 64'd2);
        check("sd_no_read",    64'(n_reads - base),     64'd0);
        run_txn(1'b0, 3'b011, 64'h8, 64'h0, 1, c0);
        check("ld_after_sd", last_resp_data, 64'hDEADBEEF00000000);

        // Sign/zero extension and mixed memory latencies.
        run_txn(1'b0, 3'b001, 64'h30, 64'h0, 2, c0);
        check("lh_data", last_resp_data, 64'hFFFFFFFFFFFFF00D);
        run_txn(1'b0, 3'b101, 64'h30, 64'h0, 3, c0);
        run_txn(1'b0, 3'b010, 64'h30, 64'h0, 1, c0);
        check("lw_data", last_resp_data, 64'hFFFFFFFF8000F00D);
        run_txn(1'b0, 3'b110, 64'h30, 64'h0, 5, c0);
        run_txn(1'b1, 3'b001, 64'h30, 64'h0000_0000_0000_1234, 3, c0);
        run_txn(1'b1, 3'b010, 64'h34, 64'h0000_0000_CAFE_BABE, 1, c0);
        run_txn(1'b0, 3'b011, 64'h30, 64'h0, 16, c0);
        check("ld_after_sh_sw", last_resp_data, 64'hCAFEBABE80001234);

        // Timeout: no mem_valid, error after 16 WAIT cycles, late pulse ignored.
        base = n_resp;
        run_txn(1'b0, 3'b011, 64'h10, 64'h0, 0, c0);
        check("to_resp_cycle", 64'(last_resp_cyc - c0), 64'd18);
        check("to_err",        64'(last_resp_err),      64'h1);
        mem_valid = 1'b1; mem_rdata = 64'h1234;
        idle(1);
        mem_valid = 1'b0; mem_rdata = 64'h0;
        idle(3);
        check("to_single_resp", 64'(n_resp - base), 64'd1);
        base = n_writes;
        run_txn(1'b1, 3'b000, 64'h20, 64'h55, 17, c0);
        check("to_store_no_write", 64'(n_writes - base), 64'd0);

        // Illegal funct3 combinations: immediate error, no access.
        base = n_reads + n_writes;
        run_txn(1'b0, 3'b111, 64'h10, 64'h0, 2, c0);
        check("bad_f3_cycle", 64'(last_resp_cyc - c0), 64'd1);
        run_txn(1'b1, 3'b100, 64'h10, 64'h0, 2, c0);
        run_txn(1'b1, 3'b110, 64'h10, 64'h0, 2, c0);
        check("bad_f3_no_access", 64'(n_reads + n_writes - base), 64'd0);

        // LW at 0x3.
        run_txn(1'b0, 3'b010, 64'h3, 64'h0, 2, c0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("lw_mis_cycle", 64'(last_resp_cyc - c0), 64'd1);
        check("lw_mis_err",   64'(last_resp_err),      64'h1);
`else
        check("lw_mis_cycle", 64'(last_resp_cyc - c0), 64'd4);
        check("lw_mis_data",  last_resp_data,          64'h0000000006050403);
`endif

        // Reset pulse during WAIT of an SH: outputs clear, write aborted.
        base = n_writes;
        check_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 64'h40; req_wdata = 64'h5555;
        idle(1);
        req_valid = 1'b0;
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready",      64'(req_ready),  64'h0);
        check("rst_MemRead",    64'(mem_read),   64'h0);
        check("rst_MemWrite",   64'(mem_write),  64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_mem_data",   mem_wdata,       64'h0);
        exp_tab.delete();
        mem_valid = 1'b1; mem_rdata = 64'hFFFF;
        idle(2);
        mem_valid = 1'b0; mem_rdata = 64'h0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("rst_release_ready", 64'(req_ready), 64'h1);
        check_en = 1'b1;
        idle(6);
        check("rst_no_write", 64'(n_writes - base), 64'd0);

        run_txn(1'b0, 3'b011, 64'h10, 64'h0, 2, c0);
        check("ld_after_rst", last_resp_data, 64'h8877665544332211);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
